// File: rtl/modport_spi_slave_pkg.sv
// Shared SPI mode definitions, synchroniser depth and CPOL/CPHA decoding
// for the SPI slave slice.
package spi_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } spi_mode_t;

    localparam int SYNC_STAGES = 2;

    function automatic logic cpol(input spi_mode_t mode);
        logic [1:0] bits;
        bits = mode;
        return bits[1];
    endfunction

    function automatic logic cpha(input spi_mode_t mode);
        logic [1:0] bits;
        bits = mode;
        return bits[0];
    endfunction

endpackage

// File: rtl/modport_spi_slave_if.sv
// Byte-side handshake between on-chip host logic and the SPI slave:
// the host pushes TX bytes and receives RX bytes with one-cycle strobes.
interface modport_spi_slave_if #(
    parameter int WIDTH = 8
);
    logic             TX_DV;
    logic [WIDTH-1:0] TX_Byte;
    logic             RX_DV;
    logic [WIDTH-1:0] RX_Byte;

    modport master (
        output TX_DV,
        output TX_Byte,
        input  RX_DV,
        input  RX_Byte
    );

    modport slave (
        input  TX_DV,
        input  TX_Byte,
        output RX_DV,
        output RX_Byte
    );
endinterface

// File: rtl/modport_spi_slave_sync_edge.sv
// Brings an asynchronous SPI pin into the i_Clk domain and flags its
// rising and falling transitions for one cycle each.
module spi_sync_edge
    import spi_pkg::*;
(
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Async,
    output logic o_Rise,
    output logic o_Fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_Async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_Rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign o_Fall = ~sync_q[SYNC_STAGES-1] & prev_q;
endmodule

// File: rtl/modport_spi_slave.sv
// Oversampling SPI slave: deserialises MOSI into byte strobes and serialises
// a host-supplied byte onto MISO, MSB first, in any of the four SPI modes.
module modport_spi_slave
    import spi_pkg::*;
#(
    parameter int SPI_MODE = 0,
    parameter int WIDTH    = 8
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    modport_spi_slave_if.slave hostIf,
    input  logic               i_SPI_Clk,
    input  logic               i_SPI_CS_n,
    input  logic               i_SPI_MOSI,
    output logic               o_SPI_MISO
);
    localparam spi_mode_t      MODE = spi_mode_t'(SPI_MODE[1:0]);
    localparam logic           CPOL = cpol(MODE);
    localparam logic           CPHA = cpha(MODE);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic sclkRise, sclkFall, csRise, csFall;
    logic leadingEdge, trailingEdge, sampleEdge, shiftEdge;
    logic [SYNC_STAGES-1:0] mosiSync_q;

    logic [WIDTH-1:0] rxShift_q, rxShift_d, rxByte_q, rxByte_d;
    logic [CW-1:0]    rxCnt_q, rxCnt_d, txCnt_q, txCnt_d;
    logic             rxDv_q, rxDv_d;
    logic [WIDTH-1:0] txHold_q, txHold_d, txShift_q, txShift_d;
    logic             txFirst_q, txFirst_d;
    logic             en_q, en_d;

    spi_sync_edge u_sclkSync (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Async(i_SPI_Clk),
        .o_Rise (sclkRise),
        .o_Fall (sclkFall)
    );

    spi_sync_edge u_csSync (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Async(i_SPI_CS_n),
        .o_Rise (csRise),
        .o_Fall (csFall)
    );

    assign leadingEdge  = CPOL ? sclkFall : sclkRise;
    assign trailingEdge = CPOL ? sclkRise : sclkFall;
    assign sampleEdge   = CPHA ? trailingEdge : leadingEdge;
    assign shiftEdge    = CPHA ? leadingEdge : trailingEdge;

    // The slave only becomes active on an observed CS_n fall, so a reset
    // in the middle of a transfer stays idle until the master reselects it.
    always_comb begin
        en_d      = en_q;
        rxShift_d = rxShift_q;
        rxCnt_d   = rxCnt_q;
        rxByte_d  = rxByte_q;
        rxDv_d    = 1'b0;
        txHold_d  = hostIf.TX_DV ? hostIf.TX_Byte : txHold_q;
        txShift_d = txShift_q;
        txCnt_d   = txCnt_q;
        txFirst_d = txFirst_q;

        if (csFall) begin
            en_d = 1'b1;
        end else if (csRise) begin
            en_d = 1'b0;
        end

        if (!en_q) begin
            rxShift_d = '0;
            rxCnt_d   = '0;
            txShift_d = txHold_d;
            txCnt_d   = '0;
            txFirst_d = 1'b1;
        end else begin
            if (sampleEdge) begin
                rxShift_d = {rxShift_q[WIDTH-2:0], mosiSync_q[SYNC_STAGES-1]};
                if (rxCnt_q == LAST) begin
                    rxByte_d = rxShift_d;
                    rxDv_d   = 1'b1;
                    rxCnt_d  = '0;
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            // CPHA=1 presents each MSB on the leading edge that opens a byte;
            // the first byte is already loaded, later ones load here.
            if (shiftEdge) begin
                if (CPHA) begin
                    if (txCnt_q == '0) begin
                        if (!txFirst_q) begin
                            txShift_d = txHold_d;
                        end
                    end else begin
                        txShift_d = {txShift_q[WIDTH-2:0], 1'b0};
                    end
                    txFirst_d = 1'b0;
                end else begin
                    if (txCnt_q == LAST) begin
                        txShift_d = txHold_d;
                    end else begin
                        txShift_d = {txShift_q[WIDTH-2:0], 1'b0};
                    end
                end
                txCnt_d = (txCnt_q == LAST) ? '0 : txCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            mosiSync_q <= '0;
            en_q       <= 1'b0;
            rxShift_q  <= '0;
            rxCnt_q    <= '0;
            rxByte_q   <= '0;
            rxDv_q     <= 1'b0;
            txHold_q   <= '0;
            txShift_q  <= '0;
            txCnt_q    <= '0;
            txFirst_q  <= 1'b1;
        end else begin
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
            en_q       <= en_d;
            rxShift_q  <= rxShift_d;
            rxCnt_q    <= rxCnt_d;
            rxByte_q   <= rxByte_d;
            rxDv_q     <= rxDv_d;
            txHold_q   <= txHold_d;
            txShift_q  <= txShift_d;
            txCnt_q    <= txCnt_d;
            txFirst_q  <= txFirst_d;
        end
    end

    assign hostIf.RX_DV   = rxDv_q;
    assign hostIf.RX_Byte = rxByte_q;
    assign o_SPI_MISO     = en_q ? txShift_q[WIDTH-1] : 1'bz;
endmodule

// File: tb/tb_modport_spi_slave.sv
// Drives one slave per SPI mode with a bit-banged master and compares the
// bytes seen on both sides against a byte-level model of the host.
module tb_modport_spi_slave;
    localparam int HALF = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      sclk, csN, mosi, txDv;
    logic [3:0][7:0] txByte;
    wire  [3:0]      rxDv;
    wire  [3:0][7:0] rxByte;
    wire  [3:0]      misoLine;

    logic [3:0][7:0] expHold;
    logic [3:0][7:0] lastRx;
    logic [3:0][7:0] prevRx;
    int              dvCount [4] = '{0, 0, 0, 0};
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : gMode
        wire misoW;
        modport_spi_slave_if #(.WIDTH(8)) hostIf ();
        assign hostIf.TX_DV   = txDv[m];
        assign hostIf.TX_Byte = txByte[m];
        assign rxDv[m]        = hostIf.RX_DV;
        assign rxByte[m]      = hostIf.RX_Byte;
        pullup (misoW);
        assign misoLine[m]    = misoW;

        modport_spi_slave #(.SPI_MODE(m), .WIDTH(8)) dut (
            .i_Clk     (clk),
            .i_Rst     (rst),
            .hostIf    (hostIf),
            .i_SPI_Clk (sclk[m]),
            .i_SPI_CS_n(csN[m]),
            .i_SPI_MOSI(mosi[m]),
            .o_SPI_MISO(misoW)
        );
    end

    // Record every received-byte strobe, keeping the two most recent bytes.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rxDv[k] === 1'b1) begin
                dvCount[k]++;
                prevRx[k] = lastRx[k];
                lastRx[k] = rxByte[k];
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic loadTx(input int m, input logic [7:0] b);
        txByte[m] = b;
        txDv[m]   = 1'b1;
        waitClk(1);
        txDv[m]   = 1'b0;
        expHold[m] = b;
    endtask

    task automatic csLow(input int m);
        csN[m] = 1'b0;
        waitClk(8);
    endtask

    task automatic csHigh(input int m);
        csN[m]  = 1'b1;
        mosi[m] = 1'b0;
        waitClk(8);
    endtask

    // Bit-banged master: n bits of mo out MSB first, MISO captured into mi.
    task automatic spiBits(input int m, input logic [7:0] mo, input int n, output logic [7:0] mi);
        logic [1:0] mb;
        mb = m[1:0];
        mi = '0;
        for (int i = 0; i < n; i++) begin
            if (mb[0] == 1'b0) begin
                mosi[m] = mo[7-i];
                waitClk(HALF);
                mi[7-i] = misoLine[m];
                sclk[m] = ~mb[1];
                waitClk(HALF);
                sclk[m] = mb[1];
            end else begin
                sclk[m] = ~mb[1];
                mosi[m] = mo[7-i];
                waitClk(HALF);
                mi[7-i] = misoLine[m];
                sclk[m] = mb[1];
                waitClk(HALF);
            end
        end
    endtask

    task automatic applyStimulus(input int m, input logic [7:0] mo, input string tag);
        logic [7:0] mi, expMiso;
        int base;
        base = dvCount[m];
        csLow(m);
        expMiso = expHold[m];
        spiBits(m, mo, 8, mi);
        waitClk(HALF);
        csHigh(m);
        checkOutput({tag, " rxdv"}, dvCount[m], base + 1);
        checkOutput({tag, " rxbyte"}, lastRx[m], mo);
        checkOutput({tag, " miso"}, mi, expMiso);
        checkOutput({tag, " misoZ"}, misoLine[m], 1'b1);
    endtask

    task automatic backToBack(input int m);
        logic [7:0] mi1, mi2, exp1, exp2;
        int base;
        loadTx(m, 8'h9E);
        base = dvCount[m];
        csLow(m);
        exp1 = expHold[m];
        fork
            spiBits(m, 8'h12, 8, mi1);
            begin
                waitClk(4 * HALF);
                loadTx(m, 8'h61);
            end
        join
        exp2 = expHold[m];
        spiBits(m, 8'h34, 8, mi2);
        waitClk(HALF);
        csHigh(m);
        checkOutput($sformatf("b2b_m%0d rxdv", m), dvCount[m], base + 2);
        checkOutput($sformatf("b2b_m%0d rx1", m), prevRx[m], 8'h12);
        checkOutput($sformatf("b2b_m%0d rx2", m), lastRx[m], 8'h34);
        checkOutput($sformatf("b2b_m%0d miso1", m), mi1, exp1);
        checkOutput($sformatf("b2b_m%0d miso2", m), mi2, exp2);
    endtask

    initial begin
        logic [7:0] mi;
        int base;
        rst     = 1'b1;
        sclk    = 4'b1100;
        csN     = 4'b1111;
        mosi    = 4'b0000;
        txDv    = 4'b0000;
        txByte  = '0;
        expHold = '0;
        lastRx  = '0;
        prevRx  = '0;
        waitClk(3);
        rst = 1'b0;
        waitClk(6);

        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("reset_rxbyte_m%0d", k), rxByte[k], 8'h00);
            checkOutput($sformatf("reset_rxdv_m%0d", k), rxDv[k], 1'b0);
            checkOutput($sformatf("reset_misoZ_m%0d", k), misoLine[k], 1'b1);
        end

        applyStimulus(0, 8'hA5, "m0_a5");
        loadTx(0, 8'h3C);
        applyStimulus(0, 8'($urandom), "m0_tx3c");

        for (int k = 1; k < 4; k++) begin
            loadTx(k, 8'hC3);
            applyStimulus(k, 8'h5A, $sformatf("duplex_m%0d", k));
        end

        for (int k = 0; k < 4; k++) begin
            backToBack(k);
        end

        // Chip select dropped after five bits: the fragment must vanish.
        base = dvCount[0];
        csLow(0);
        spiBits(0, 8'hB6, 5, mi);
        csHigh(0);
        checkOutput("partial_nodv", dvCount[0], base);
        checkOutput("partial_misoZ", misoLine[0], 1'b1);
        applyStimulus(0, 8'hFF, "partial_ff");

        // Reset in the middle of a byte, with chip select still asserted.
        base = dvCount[0];
        csLow(0);
        spiBits(0, 8'h5C, 4, mi);
        rst = 1'b1;
        waitClk(1);
        rst = 1'b0;
        expHold = '0;
        waitClk(6);
        checkOutput("midrst_nodv", dvCount[0], base);
        checkOutput("midrst_rxbyte", rxByte[0], 8'h00);
        checkOutput("midrst_misoZ", misoLine[0], 1'b1);
        spiBits(0, 8'hE7, 8, mi);
        waitClk(HALF);
        checkOutput("midrst_idle_nodv", dvCount[0], base);
        csHigh(0);
        applyStimulus(0, 8'h81, "midrst_81");

        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    loadTx(k, 8'($urandom));
                end
                applyStimulus(k, 8'($urandom), $sformatf("rnd%0d_m%0d", it, k));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
